// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, DMA and memory bus bundle for the data memory arbiter
interface dmem_arbiter_if #(
   parameter int DATA_W = 32
);
   // CPU requester
   logic              cpu_req;
   logic              cpu_we;
   logic [31:0]       cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   // DMA / loader requester
   logic              dma_req;
   logic              dma_we;
   logic [31:0]       dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_ack;
   logic [DATA_W-1:0] dma_rdata;

   // Data memory side
   logic [31:0]       mem_add;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_read_data;

   // Status
   logic              busy;

   // Arbiter view
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata, cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_ack, dma_rdata,
      output mem_add, mem_write_data, mem_read, mem_write,
      input  mem_read_data,
      output busy
   );

   // Requester / memory environment view
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata, cpu_stall,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_ack, dma_rdata,
      input  mem_add, mem_write_data, mem_read, mem_write,
      output mem_read_data,
      input  busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter and sequencer for the single-port data memory (option macro: DMEM_ARB_ROUND_ROBIN_EN)
module dmem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;          // 0 = CPU, 1 = DMA
`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic              last_q, last_d;        // requester served most recently
`endif
   logic              rd_q, rd_d;            // current access is a read
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_add_q, mem_add_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              dma_ack_q, dma_ack_d;

   logic              any_req;
   logic              pick_dma;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Upper address bits are deliberately discarded (addresses wrap)
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.cpu_addr[31:ADDR_W], bus.dma_addr[31:ADDR_W]};

   // Pick which requester an IDLE grant would go to, and mux its request fields
   always_comb begin
      any_req = bus.cpu_req | bus.dma_req;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      pick_dma = (bus.cpu_req & bus.dma_req) ? ~last_q : ~bus.cpu_req;
`else
      pick_dma = ~bus.cpu_req;
`endif
      sel_we    = pick_dma ? bus.dma_we : bus.cpu_we;
      sel_addr  = pick_dma ? bus.dma_addr[ADDR_W-1:0] : bus.cpu_addr[ADDR_W-1:0];
      sel_wdata = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
   end

   // Next-state and next-output computation; memory drive and ack are one-cycle pulses
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_d      = last_q;
`endif
      rd_d        = rd_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_add_d   = '0;
      mem_wdata_d = '0;
      cpu_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d     = ACCESS;
               gnt_d       = pick_dma;
               rd_d        = ~sel_we;
               mem_read_d  = ~sel_we;
               mem_write_d = sel_we;
               mem_add_d   = sel_addr;
               mem_wdata_d = sel_wdata;
            end
         end
         ACCESS: begin
            state_d   = RESP;
            cpu_ack_d = ~gnt_q;
            dma_ack_d = gnt_q;
         end
         RESP: begin
            state_d = IDLE;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_d  = gnt_q;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM and registered outputs; reset aborts any access in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_q       <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         last_q      <= 1'b1;
`endif
         rd_q        <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_add_q   <= '0;
         mem_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         last_q      <= last_d;
`endif
         rd_q        <= rd_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_add_q   <= mem_add_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
      end
   end

   // Strobes are gated by reset so an access aborted in ACCESS never commits
   assign bus.mem_read       = mem_read_q & ~reset;
   assign bus.mem_write      = mem_write_q & ~reset;
   assign bus.mem_add        = {{(32-ADDR_W){1'b0}}, mem_add_q};
   assign bus.mem_write_data = mem_wdata_q;

   // Read data comes straight from the registered memory output in the ack cycle
   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.dma_ack   = dma_ack_q;
   assign bus.cpu_rdata = (cpu_ack_q & rd_q) ? bus.mem_read_data : '0;
   assign bus.dma_rdata = (dma_ack_q & rd_q) ? bus.mem_read_data : '0;

   assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
   assign bus.busy      = (state_q != IDLE);

endmodule
